// File: rtl/serial_bit_copier.sv
// rtl/serial_bit_copier.sv - round-robin multi-channel copier moving one bit per cycle, LSB first
module serial_bit_copier #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 2,
    localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int BW      = $clog2(WIDTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       req,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    output logic [CHANNELS-1:0]       ack,
    output logic [CHANNELS*WIDTH-1:0] data_out,
    output logic [CHANNELS-1:0]       done,
    output logic                      busy,
    output logic [CW-1:0]             active_ch,
    output logic [BW-1:0]             bit_idx
);

    typedef enum logic [1:0] {IDLE, COPY, DONE} state_t;

    state_t                      state_q, state_d;
    logic [CHANNELS-1:0]         ack_q, ack_d;
    logic [CHANNELS-1:0]         done_q, done_d;
    logic [CHANNELS*WIDTH-1:0]   data_out_q, data_out_d;
    logic [WIDTH-1:0]            snap_q, snap_d;
    logic [CW-1:0]               active_q, active_d;
    logic [BW-1:0]               bit_q, bit_d;
    logic [CW-1:0]               last_q, last_d;

    logic                        grant_found;
    logic [CW-1:0]               grant_ch;
    logic [CW-1:0]               cand;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ack_q      <= '0;
            done_q     <= '0;
            data_out_q <= '0;
            snap_q     <= '0;
            active_q   <= '0;
            bit_q      <= '0;
            last_q     <= CW'(CHANNELS - 1);
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            done_q     <= done_d;
            data_out_q <= data_out_d;
            snap_q     <= snap_d;
            active_q   <= active_d;
            bit_q      <= bit_d;
            last_q     <= last_d;
        end
    end

    // Round-robin search: first requester strictly after the last granted channel, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_ch    = '0;
        cand        = '0;
        for (int i = 1; i <= CHANNELS; i++) begin
            cand = CW'((int'(last_q) + i) % CHANNELS);
            for (int k = 0; k < CHANNELS; k++) begin
                if (!grant_found && req[k] && (CW'(k) == cand)) begin
                    grant_found = 1'b1;
                    grant_ch    = cand;
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ack_d      = '0;
        done_d     = '0;
        data_out_d = data_out_q;
        snap_d     = snap_q;
        active_d   = active_q;
        bit_d      = bit_q;
        last_d     = last_q;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    for (int k = 0; k < CHANNELS; k++) begin
                        if (CW'(k) == grant_ch) begin
                            ack_d[k] = 1'b1;
                            snap_d   = data_in[k*WIDTH +: WIDTH];
                        end
                    end
                    active_d = grant_ch;
                    bit_d    = '0;
                    state_d  = COPY;
                end
            end
            COPY: begin
                // Only the addressed bit of the active slice is touched; all else holds.
                for (int k = 0; k < CHANNELS; k++) begin
                    for (int b = 0; b < WIDTH; b++) begin
                        if ((CW'(k) == active_q) && (BW'(b) == bit_q)) begin
                            data_out_d[k*WIDTH + b] = snap_q[b];
                        end
                    end
                end
                if (bit_q == BW'(WIDTH - 1)) begin
                    bit_d   = '0;
                    state_d = DONE;
                end else begin
                    bit_d = bit_q + BW'(1);
                end
            end
            DONE: begin
                for (int k = 0; k < CHANNELS; k++) begin
                    if (CW'(k) == active_q) begin
                        done_d[k] = 1'b1;
                    end
                end
                last_d   = active_q;
                active_d = '0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ack       = ack_q;
    assign done      = done_q;
    assign data_out  = data_out_q;
    assign busy      = (state_q != IDLE);
    assign active_ch = active_q;
    assign bit_idx   = bit_q;

endmodule
